// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   usr_mode_e  : MODE encodings (hold, shift right, shift left, parallel load)
//   usr_state_e : sequencer FSM states (IDLE, SHIFT)
package usr_pkg;

    typedef enum logic [1:0] {
        ModeHold  = 2'b00,
        ModeRight = 2'b01,
        ModeLeft  = 2'b10,
        ModeLoad  = 2'b11
    } usr_mode_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_seq_ctrl.sv
// Multi-cycle shift sequencer: FSM, shift counter, BUSY and DONE.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mode, start     live MODE / START request
//   amt             requested shift count (clamped to WIDTH)
//   rot             live rotate select, latched at START
//   take            a shift request is being accepted this cycle (datapath holds)
//   busy            sequencer is in SHIFT
//   dir_left        latched direction (1 = left)
//   rot_lat         latched rotate select
//   done            one-cycle completion pulse (registered)
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic [CW-1:0] amt,
    input  logic          rot,
    output logic          take,
    output logic          busy,
    output logic          dir_left,
    output logic          rot_lat,
    output logic          done
);

    usr_state_e    state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] amt_clamped;
    logic          dir_left_q;
    logic          rot_q;
    logic          done_q;

    // Only shift modes form a request; hold/load with START behave as plain MODE.
    assign take        = (state_q == StIdle) && start &&
                         ((mode == ModeRight) || (mode == ModeLeft));
    assign amt_clamped = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            dir_left_q <= 1'b0;
            rot_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (take) begin
                        if (amt == '0) begin
                            // Zero-length request completes immediately.
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= StShift;
                            count_q    <= amt_clamped;
                            dir_left_q <= (mode == ModeLeft);
                            rot_q      <= rot;
                        end
                    end
                end
                StShift: begin
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = (state_q == StShift);
    assign dir_left = dir_left_q;
    assign rot_lat  = rot_q;
    assign done     = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with hold / shift right / shift left / parallel load,
// plus a multi-cycle shift of AMT positions started by START.
// Optional feature: define USR_ROTATE_EN to add the ROT input (rotate instead of
// taking the serial inputs).
// Ports:
//   E            clock (rising edge)
//   RN           asynchronous active-low reset
//   ROT          rotate select (only with USR_ROTATE_EN)
//   MODE         00 hold, 01 right, 10 left, 11 load
//   D            parallel load data
//   SI_R / SI_L  serial inputs entering at MSB (right) / LSB (left)
//   START, AMT   multi-cycle shift request and amount
//   Q            register contents
//   SO_R / SO_L  Q[0] / Q[WIDTH-1]
//   BUSY, DONE   multi-cycle shift in progress / completion pulse
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic             E,
    input  logic             RN,
`ifdef USR_ROTATE_EN
    input  logic             ROT,
`endif
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_R,
    input  logic             SI_L,
    input  logic             START,
    input  logic [CW-1:0]    AMT,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shr, shl;
    logic             take, busy, dir_left, rot_lat, rot_live, rot_sel;

`ifdef USR_ROTATE_EN
    assign rot_live = ROT;
`else
    assign rot_live = 1'b0;
`endif

    usr_seq_ctrl #(
        .WIDTH(WIDTH)
    ) u_seq_ctrl (
        .clk      (E),
        .rst_n    (RN),
        .mode     (MODE),
        .start    (START),
        .amt      (AMT),
        .rot      (rot_live),
        .take     (take),
        .busy     (busy),
        .dir_left (dir_left),
        .rot_lat  (rot_lat),
        .done     (DONE)
    );

    // During SHIFT the rotate select comes from the START-time latch.
    assign rot_sel = busy ? rot_lat : rot_live;
    assign shr     = {(rot_sel ? q_q[0] : SI_R), q_q[WIDTH-1:1]};
    assign shl     = {q_q[WIDTH-2:0], (rot_sel ? q_q[WIDTH-1] : SI_L)};

    always_comb begin
        q_d = q_q;
        if (busy) begin
            q_d = dir_left ? shl : shr;
        end else if (!take) begin
            case (MODE)
                ModeRight: q_d = shr;
                ModeLeft:  q_d = shl;
                ModeLoad:  q_d = D;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge E or negedge RN) begin
        if (!RN) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign SO_R = q_q[0];
    assign SO_L = q_q[WIDTH-1];
    assign BUSY = busy;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=8): stimulus pushes the
// hand-computed post-edge state; a monitor pops and compares at each falling edge
// (or on demand for the asynchronous-reset checks).
module tb_universal_shift_register;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          E = 1'b0;
    logic          RN;
    logic          ROT;
    logic [1:0]    MODE;
    logic [W-1:0]  D;
    logic          SI_R, SI_L, START;
    logic [CW-1:0] AMT;
    logic [W-1:0]  Q;
    logic          SO_R, SO_L, BUSY, DONE;

    universal_shift_register #(
        .WIDTH(W)
    ) dut (
        .E     (E),
        .RN    (RN),
`ifdef USR_ROTATE_EN
        .ROT   (ROT),
`endif
        .MODE  (MODE),
        .D     (D),
        .SI_R  (SI_R),
        .SI_L  (SI_L),
        .START (START),
        .AMT   (AMT),
        .Q     (Q),
        .SO_R  (SO_R),
        .SO_L  (SO_L),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 E = ~E;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    event sample_now;

    // Monitor: compare the oldest expectation against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge E or sample_now);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (Q !== e.q || BUSY !== e.busy || DONE !== e.done ||
                    SO_R !== e.q[0] || SO_L !== e.q[W-1]) begin
                    n_err++;
                    $display("FAIL %s: got Q=%h BUSY=%b DONE=%b SO_R=%b SO_L=%b, want Q=%h BUSY=%b DONE=%b SO_R=%b SO_L=%b",
                             e.name, Q, BUSY, DONE, SO_R, SO_L,
                             e.q, e.busy, e.done, e.q[0], e.q[W-1]);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [W-1:0] q, input logic b, input logic d);
        exp_t e;
        e.name = nm;
        e.q    = q;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    // Apply current inputs on the next rising edge, then record the expected result.
    task automatic tick(input string nm, input logic [W-1:0] q, input logic b, input logic d);
        @(posedge E);
        #1;
        push(nm, q, b, d);
    endtask

    // Immediate check without waiting for an edge.
    task automatic chk_now(input string nm, input logic [W-1:0] q, input logic b, input logic d);
        push(nm, q, b, d);
        -> sample_now;
        #0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RN = 1'b0; ROT = 1'b0; MODE = 2'b00; D = '0;
        SI_R = 1'b0; SI_L = 1'b0; START = 1'b0; AMT = '0;
        #2;
        chk_now("reset", 8'h00, 1'b0, 1'b0);
        @(negedge E);
        RN = 1'b1;

        // Load then hold.
        MODE = 2'b11; D = 8'hA5;
        tick("load_a5", 8'hA5, 1'b0, 1'b0);
        MODE = 2'b00; D = 8'h00;
        for (int i = 0; i < 3; i++) tick("hold_a5", 8'hA5, 1'b0, 1'b0);

        // Single right shift; SO_R is 1 before the edge, 0 after.
        MODE = 2'b11; D = 8'h81;
        tick("load_81", 8'h81, 1'b0, 1'b0);
        MODE = 2'b01; SI_R = 1'b0;
        tick("shr_81", 8'h40, 1'b0, 1'b0);

        // Multi-cycle left shift by 3 with MODE disturbed while busy.
        MODE = 2'b11; D = 8'h01;
        tick("load_01", 8'h01, 1'b0, 1'b0);
        START = 1'b1; MODE = 2'b10; AMT = 4'd3; SI_L = 1'b1; D = 8'hFF;
        tick("start_l3", 8'h01, 1'b1, 1'b0);
        START = 1'b0; MODE = 2'b11;
        tick("shl_1", 8'h03, 1'b1, 1'b0);
        MODE = 2'b01;
        tick("shl_2", 8'h07, 1'b1, 1'b0);
        MODE = 2'b00;
        tick("shl_3", 8'h0F, 1'b0, 1'b1);
        tick("after_l3", 8'h0F, 1'b0, 1'b0);

        // Zero-length request.
        START = 1'b1; MODE = 2'b01; AMT = 4'd0; SI_R = 1'b1;
        tick("amt0", 8'h0F, 1'b0, 1'b1);
        START = 1'b0; MODE = 2'b00;
        tick("amt0_after", 8'h0F, 1'b0, 1'b0);

        // Amount above WIDTH is clamped to 8 shifts.
        START = 1'b1; MODE = 2'b01; AMT = 4'd12; SI_R = 1'b1;
        tick("start_r12", 8'h0F, 1'b1, 1'b0);
        START = 1'b0; MODE = 2'b00;
        tick("shr_1", 8'h87, 1'b1, 1'b0);
        tick("shr_2", 8'hC3, 1'b1, 1'b0);
        tick("shr_3", 8'hE1, 1'b1, 1'b0);
        tick("shr_4", 8'hF0, 1'b1, 1'b0);
        tick("shr_5", 8'hF8, 1'b1, 1'b0);
        tick("shr_6", 8'hFC, 1'b1, 1'b0);
        tick("shr_7", 8'hFE, 1'b1, 1'b0);
        tick("shr_8", 8'hFF, 1'b0, 1'b1);
        SI_R = 1'b0;
        tick("after_r12", 8'hFF, 1'b0, 1'b0);

        // START with load mode is not a request.
        START = 1'b1; MODE = 2'b11; D = 8'h3C; AMT = 4'd2;
        tick("start_load", 8'h3C, 1'b0, 1'b0);
        START = 1'b0; MODE = 2'b00;
        tick("start_load_after", 8'h3C, 1'b0, 1'b0);

        // Asynchronous reset mid-shift while Q=0x5A.
        MODE = 2'b11; D = 8'hB4;
        tick("load_b4", 8'hB4, 1'b0, 1'b0);
        START = 1'b1; MODE = 2'b01; AMT = 4'd5; SI_R = 1'b0;
        tick("start_r5", 8'hB4, 1'b1, 1'b0);
        START = 1'b0; MODE = 2'b00;
        tick("mid_5a", 8'h5A, 1'b1, 1'b0);
        @(negedge E);
        #2;
        RN = 1'b0;
        #1;
        chk_now("rst_mid", 8'h00, 1'b0, 1'b0);
        #1;
        RN = 1'b1;
        tick("no_resume_1", 8'h00, 1'b0, 1'b0);
        tick("no_resume_2", 8'h00, 1'b0, 1'b0);

`ifdef USR_ROTATE_EN
        MODE = 2'b11; D = 8'h81;
        tick("rot_load", 8'h81, 1'b0, 1'b0);
        MODE = 2'b01; ROT = 1'b1; SI_R = 1'b0;
        tick("rot_r", 8'hC0, 1'b0, 1'b0);
        MODE = 2'b00; ROT = 1'b0;
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge E);
        #1;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Localparam CW = $clog2(WIDTH+1), width of the shift-amount input.
REQ-003 E  input  1  clock; all state SHALL update on the rising edge.
REQ-004 RN  input  1  reset; asynchronous, active-low.
REQ-005 MODE  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 D  input  WIDTH  parallel load data.
REQ-007 SI_R  input  1  serial input entering at the MSB on a right shift.
REQ-008 SI_L  input  1  serial input entering at the LSB on a left shift.
REQ-009 START  input  1  request a multi-cycle shift of AMT positions in the MODE direction.
REQ-010 AMT  input  CW  shift amount sampled with START.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 SO_R / SO_L  output  1 each  Q[0] / Q[WIDTH-1], combinational from Q.
REQ-013 BUSY  output  1  high while the multi-cycle shift is in progress.
REQ-014 DONE  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be exactly IDLE and SHIFT.
REQ-016 In IDLE with START=0, each edge SHALL apply MODE: hold; Q <= {SI_R, Q[W-1:1]}; Q <= {Q[W-2:0], SI_L}; or Q <= D.
REQ-017 In IDLE, START=1 with MODE 01/10 and AMT>0 SHALL latch the direction and count = min(AMT, WIDTH), enter SHIFT, and leave Q unchanged on that edge.
REQ-018 AMT > WIDTH SHALL be clamped to WIDTH.
REQ-019 In SHIFT, each edge SHALL perform one shift in the latched direction using live SI_R/SI_L and decrement count.
REQ-020 The edge that performs the final shift SHALL return the FSM to IDLE and assert DONE for exactly one cycle, concurrent with the final Q.
REQ-021 Q SHALL hold the final value AMT edges after the START edge.
REQ-022 BUSY SHALL equal (state == SHIFT).
REQ-023 In SHIFT, MODE, D, START and AMT SHALL be ignored.
REQ-024 START=1 with AMT=0 in IDLE SHALL leave Q unchanged, stay in IDLE and pulse DONE on the next cycle.
REQ-025 START=1 with MODE 00/11 SHALL be ignored as a request; MODE SHALL apply normally and DONE SHALL stay low.
REQ-026 DONE SHALL be low in every cycle not covered by REQ-020 or REQ-024.

Reset
REQ-027 RN low SHALL immediately force Q=0, BUSY=0, DONE=0 and state IDLE, including mid-shift.
REQ-028 After RN rises, operation SHALL begin on the first rising edge of E; no pending shift SHALL resume.

Configuration
REQ-029 Macro USR_ROTATE_EN defined: add input port ROT (1 bit); with ROT=1 the shifted-out bit SHALL re-enter at the opposite end in place of SI_R/SI_L; ROT SHALL be latched at START for SHIFT.
REQ-030 USR_ROTATE_EN undefined: no ROT port; shifts SHALL always use the serial inputs.

Structure
REQ-031 Package usr_pkg SHALL hold the MODE encodings and the FSM state type.
REQ-032 Sub-module usr_seq_ctrl SHALL contain the FSM, counter, BUSY and DONE; the datapath register SHALL stay in the top module.

Verification (WIDTH=8)
REQ-033 RN pulsed low mid-shift with Q=0x5A -> Q=0x00, BUSY=0, DONE=0 immediately, no edge required.
REQ-034 MODE=11, D=0xA5, one edge -> Q=0xA5; MODE=00 for three edges -> Q stays 0xA5.
REQ-035 Q=0x81, MODE=01, SI_R=0, one edge -> Q=0x40; SO_R reads 1 before the edge and 0 after.
REQ-036 Q=0x01, START=1, MODE=10, AMT=3, SI_L=1, MODE toggled during BUSY -> BUSY for 3 cycles, Q=0x0F, DONE high for one cycle only.
REQ-037 START with AMT=0 -> DONE pulses next cycle, Q unchanged; START with AMT=12, SI_R=1 -> exactly 8 shifts, Q=0xFF.
REQ-038 With USR_ROTATE_EN: Q=0x81, ROT=1, MODE=01, one edge -> Q=0xC0.
